// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] PTR_RST = 3'd7;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request/grant bundle; master = arbiter side, slave = requester side.
// RR_ARBITER_STATS_EN adds the grant_count/expire_count statistics signals.
interface rr_arbiter_8_if;
    logic [arb_pkg::NUM_REQ-1:0] req;
    logic [arb_pkg::NUM_REQ-1:0] grant;
    logic [arb_pkg::IDX_W-1:0] grant_idx;
    logic grant_valid;
    logic hold_expired;
`ifdef RR_ARBITER_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] expire_count;
    modport master(input req, output grant, grant_idx, grant_valid, hold_expired, grant_count, expire_count);
    modport slave(output req, input grant, grant_idx, grant_valid, hold_expired, grant_count, expire_count);
`else
    modport master(input req, output grant, grant_idx, grant_valid, hold_expired);
    modport slave(output req, input grant, grant_idx, grant_valid, hold_expired);
`endif
endinterface

// File: rtl/onehot_dec3to8.sv
// onehot_dec3to8: combinational 3-bit index to 8-bit one-hot decoder.
module onehot_dec3to8 (
    input  logic [2:0] idx,
    output logic [7:0] onehot
);
    assign onehot = 8'b1 << idx;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-requester round-robin arbiter with hold limit and break-before-make gap.
// Optional RR_ARBITER_STATS_EN adds saturating grant/expire counters.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    rr_arbiter_8_if.master bus
);
    // First set request strictly after p, wrapping; smallest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w;
        w = p;
        for (int k = NUM_REQ; k >= 1; k--)
            if (r[IDX_W'(int'(p) + k)]) w = IDX_W'(int'(p) + k);
        return w;
    endfunction

    state_t state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, win_oh;
    logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, win;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic exp_q, exp_d;
    logic start;

    assign win = rr_pick(bus.req, ptr_q);
    assign start = (state_q == IDLE) && (|bus.req);

    onehot_dec3to8 u_dec (.idx(win), .onehot(win_oh));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        exp_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = GRANT;
                grant_d = win_oh;
                idx_d = win;
                ptr_d = win;
                cnt_d = CNT_W'(1);
            end
            GRANT: if (!bus.req[idx_q]) begin
                state_d = GAP;
                grant_d = '0;
            end else if (cnt_q == CNT_W'(HOLD_MAX)) begin
                state_d = GAP;
                grant_d = '0;
                exp_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q <= PTR_RST;
            ptr_q <= PTR_RST;
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q <= idx_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.grant_valid = |grant_q;
    assign bus.hold_expired = exp_q;

`ifdef RR_ARBITER_STATS_EN
    logic [15:0] gcnt_q, gcnt_d, ecnt_q, ecnt_d;

    always_comb begin
        gcnt_d = (start && gcnt_q != 16'hFFFF) ? gcnt_q + 16'd1 : gcnt_q;
        ecnt_d = (exp_d && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign bus.grant_count = gcnt_q;
    assign bus.expire_count = ecnt_q;
`endif
endmodule
